board_tx_sequencer: RTL and testbench

Packetizes the analyzer's 188-bit board snapshot into a framed byte stream and sequences the byte-wide UART transmitter one byte at a time, using its done handshake. Sits between the analyzer/frame-trigger logic and the UART transmitter in the top level, in the 25 MHz VGA clock domain. Each packet is a header byte, 24 data bytes and an XOR checksum. A watchdog aborts a packet if the transmitter stalls.

---
 rtl/board_tx_sequencer_if.sv | 23 ++
 rtl/board_tx_sequencer.sv | 158 +++++++++++++++
 tb/tb_board_tx_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_tx_sequencer_if.sv
// Byte-wide handshake between the board packetizer and the UART transmitter.
// The sequencer side (master) presents a byte with a one-cycle valid pulse;
// the UART side (slave) reports that it is shifting and pulses done per byte.
interface board_tx_sequencer_if;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;

    modport master (
        output tx_dv,
        output tx_byte,
        input  tx_active,
        input  tx_done
    );

    modport slave (
        input  tx_dv,
        input  tx_byte,
        output tx_active,
        output tx_done
    );
endinterface

// File: rtl/board_tx_sequencer.sv
// Board snapshot packetizer for the UART link.
// A packet is HEADER, ceil(BOARD_BITS/8) data bytes (LSB byte first, zero
// padded at the top) and the XOR of all preceding bytes. One byte is issued
// per UART done handshake; a per-byte watchdog abandons a stalled packet.
module board_tx_sequencer #(
    parameter int         BOARD_BITS     = 188,
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  frame_strobe,
    input  logic [BOARD_BITS-1:0] board,
    board_tx_sequencer_if.master  tx,
    output logic                  busy,
    output logic [7:0]            drop_count,
    output logic                  timeout_err
);

    localparam int NUM_DATA = (BOARD_BITS + 7) / 8;
    localparam int LAST_IDX = NUM_DATA + 1;
    localparam int IDX_W    = $clog2(LAST_IDX + 1);
    localparam int WD_W     = $clog2(TIMEOUT_CYCLES);
    localparam int PAD_W    = 8 * NUM_DATA;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_IDX);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, ISSUE, WAIT_DONE} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [7:0]            chk, chk_nxt;
    logic [WD_W-1:0]       wd, wd_nxt;
    logic [BOARD_BITS-1:0] shadow, shadow_nxt;
    logic                  dv_q, dv_nxt;
    logic [7:0]            byte_q, byte_nxt;
    logic                  busy_nxt;
    logic [7:0]            drop_nxt;
    logic                  terr_nxt;
    logic [7:0]            cur_byte;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Data byte i (1-based) of the snapshot; bits above BOARD_BITS read as zero.
    function automatic logic [7:0] data_byte(input logic [BOARD_BITS-1:0] s,
                                             input logic [IDX_W-1:0]      i);
        logic [PAD_W-1:0] padded;
        padded                   = '0;
        padded[BOARD_BITS-1:0]   = s;
        return padded[8*(int'(i)-1) +: 8];
    endfunction

    assign tx.tx_dv   = dv_q;
    assign tx.tx_byte = byte_q;

    // Next-state, byte selection and output decisions for the packet sequencer.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        chk_nxt    = chk;
        wd_nxt     = wd;
        shadow_nxt = shadow;
        dv_nxt     = 1'b0;
        byte_nxt   = byte_q;
        busy_nxt   = busy;
        drop_nxt   = drop_count;
        terr_nxt   = timeout_err;
        cur_byte   = HEADER;

        if (idx == IDX_LAST) begin
            cur_byte = chk;
        end else if (idx != '0) begin
            cur_byte = data_byte(shadow, idx);
        end

        // busy is high for every non-IDLE cycle, including the one whose
        // edge retires the last byte, so such a strobe is a drop.
        if (frame_strobe && busy) begin
            drop_nxt = sat_inc(drop_count);
        end

        case (state)
            IDLE: begin
                if (frame_strobe && enable) begin
                    shadow_nxt = board;
                    chk_nxt    = 8'h00;
                    idx_nxt    = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = ARM;
                end
            end
            ARM: begin
                if (!tx.tx_active) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dv_nxt    = 1'b1;
                byte_nxt  = cur_byte;
                chk_nxt   = chk ^ cur_byte;
                wd_nxt    = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx.tx_done) begin
                    if (idx == IDX_LAST) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ISSUE;
                    end
                end else if (wd == WD_LAST) begin
                    terr_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            chk         <= 8'h00;
            wd          <= '0;
            shadow      <= '0;
            dv_q        <= 1'b0;
            byte_q      <= 8'h00;
            busy        <= 1'b0;
            drop_count  <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            chk         <= chk_nxt;
            wd          <= wd_nxt;
            shadow      <= shadow_nxt;
            dv_q        <= dv_nxt;
            byte_q      <= byte_nxt;
            busy        <= busy_nxt;
            drop_count  <= drop_nxt;
            timeout_err <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_board_tx_sequencer.sv
// Scoreboard bench for board_tx_sequencer: expected packet bytes are queued
// when a strobe is issued and a monitor pops them on every tx_dv pulse.
module tb_board_tx_sequencer;

    localparam int BB = 188;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          enable       = 1'b0;
    logic          frame_strobe = 1'b0;
    logic [BB-1:0] board        = '0;
    logic          busy;
    logic [7:0]    drop_count;
    logic          timeout_err;

    logic model_active = 1'b0;
    logic model_done   = 1'b0;
    logic hold_active  = 1'b0;

    board_tx_sequencer_if u ();
    assign u.tx_active = model_active | hold_active;
    assign u.tx_done   = model_done;

    board_tx_sequencer #(
        .BOARD_BITS    (BB),
        .HEADER        (8'hA5),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_strobe(frame_strobe),
        .board       (board),
        .tx          (u),
        .busy        (busy),
        .drop_count  (drop_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests       = 0;
    int         fails       = 0;
    logic [7:0] exp_q[$];
    int         mon_dv      = 0;
    int         last_dv_cyc = 0;
    int         dv_total    = 0;
    int         mute_after  = 32'h7fffffff;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected packet from the packet format: header, LSB-first data, XOR.
    task automatic push_packet(input logic [BB-1:0] b);
        logic [191:0] p;
        logic [7:0]   c;
        logic [7:0]   v;
        p = {4'b0000, b};
        c = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 24; i++) begin
            v = p[8*i +: 8];
            exp_q.push_back(v);
            c = c ^ v;
        end
        exp_q.push_back(c);
    endtask

    task automatic strobe(input logic [BB-1:0] b);
        @(negedge clk);
        board        = b;
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
    endtask

    task automatic wait_dv(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (mon_dv < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, mon_dv, target);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    // UART model: done 20 cycles after each tx_dv, busy meanwhile.
    initial begin : uart_model
        forever begin
            @(negedge clk);
            if (u.tx_dv) begin
                dv_total++;
                model_active = 1'b1;
                repeat (19) @(negedge clk);
                model_active = 1'b0;
                if (dv_total <= mute_after) begin
                    model_done = 1'b1;
                    @(negedge clk);
                    model_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every byte presented to the UART.
    initial begin : monitor
        logic       prev_dv;
        logic [7:0] e;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (u.tx_dv) begin
                mon_dv++;
                last_dv_cyc = cyc;
                check("dv_one_cycle_wide", int'(prev_dv), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(u.tx_byte) + 256, int'(u.tx_byte));
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", int'(u.tx_byte), int'(e));
                end
            end
            prev_dv = u.tx_dv;
        end
    end

    initial begin : global_guard
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [BB-1:0] b1;
        logic [BB-1:0] b2;
        int            base;
        int            k;
        int            n;

        b1 = '0;
        b1[0]   = 1'b1;
        b1[187] = 1'b1;
        b2 = 188'h0F1E2D3C4B5A69788796A5B4C3D2E1F0123456789ABCDEF;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_dv", int'(u.tx_dv), 0);
        check("rst_tx_byte", int'(u.tx_byte), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop_count", int'(drop_count), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Hand-computed packet: A5 01 00x22 08 AC
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        repeat (22) exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'hAC);
        base = mon_dv;
        strobe(b1);
        k = cyc;
        check("busy_after_strobe", int'(busy), 1);
        wait_dv(base + 1, 20, "first_dv_seen");
        check("header_latency", last_dv_cyc - k, 2);
        wait_dv(base + 26, 1000, "pkt1_all_bytes");
        wait_idle(100, "pkt1_busy_falls");
        repeat (30) @(negedge clk);
        check("pkt1_dv_count", mon_dv - base, 26);
        check("pkt1_queue_empty", exp_q.size(), 0);
        check("pkt1_no_drops", int'(drop_count), 0);

        // Six strobes while busy, with the board changing underneath
        push_packet(b2);
        base = mon_dv;
        strobe(b2);
        for (int i = 0; i < 6; i++) begin
            repeat (79) @(negedge clk);
            check("busy_at_extra_strobe", int'(busy), 1);
            strobe(~b2);
        end
        wait_idle(1000, "pkt2_busy_falls");
        check("drop_count_6", int'(drop_count), 6);
        check("pkt2_dv_count", mon_dv - base, 26);
        check("pkt2_queue_empty", exp_q.size(), 0);

        // 300 strobes while busy saturate the drop counter
        push_packet(~b2);
        base = mon_dv;
        strobe(~b2);
        repeat (2) @(negedge clk);
        frame_strobe = 1'b1;
        repeat (300) @(negedge clk);
        check("busy_through_burst", int'(busy), 1);
        frame_strobe = 1'b0;
        wait_idle(1000, "pkt3_busy_falls");
        check("drop_count_saturated", int'(drop_count), 255);
        check("pkt3_dv_count", mon_dv - base, 26);

        // UART stalls on byte 3: watchdog aborts the packet
        mute_after = dv_total + 3;
        push_packet(b2 ^ (b2 << 5));
        base = mon_dv;
        strobe(b2 ^ (b2 << 5));
        wait_dv(base + 4, 200, "stall_byte_issued");
        k = last_dv_cyc;
        n = 0;
        while (!timeout_err && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err_set", int'(timeout_err), 1);
        check("timeout_delay", cyc - k, 4096);
        check("timeout_busy_low", int'(busy), 0);
        check("timeout_bytes_left", exp_q.size(), 22);
        exp_q.delete();
        mute_after = 32'h7fffffff;
        repeat (30) @(negedge clk);
        check("timeout_no_more_bytes", mon_dv - base, 4);
        push_packet(b2 >> 7);
        base = mon_dv;
        strobe(b2 >> 7);
        wait_dv(base + 26, 1000, "post_timeout_packet");
        wait_idle(100, "post_timeout_idle");
        check("timeout_err_sticky", int'(timeout_err), 1);

        // UART still shifting when the strobe arrives
        hold_active = 1'b1;
        push_packet(~(b2 >> 3));
        base = mon_dv;
        strobe(~(b2 >> 3));
        repeat (50) @(negedge clk);
        check("no_dv_while_active", mon_dv - base, 0);
        check("busy_while_armed", int'(busy), 1);
        hold_active = 1'b0;
        k = cyc;
        wait_dv(base + 1, 20, "dv_after_active");
        check("active_release_latency", last_dv_cyc - k, 2);
        wait_dv(base + 26, 1000, "active_packet_done");
        wait_idle(100, "active_packet_idle");

        // Asynchronous reset during byte 10
        push_packet(b2 ^ 188'h5);
        base = mon_dv;
        strobe(b2 ^ 188'h5);
        wait_dv(base + 10, 400, "reach_byte_10");
        rst_n = 1'b0;
        #2;
        check("mid_rst_tx_dv", int'(u.tx_dv), 0);
        check("mid_rst_tx_byte", int'(u.tx_byte), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_drop_count", int'(drop_count), 0);
        check("mid_rst_timeout_err", int'(timeout_err), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_packet(b2 ^ 188'hFF00FF);
        base = mon_dv;
        strobe(b2 ^ 188'hFF00FF);
        wait_dv(base + 26, 1200, "post_reset_packet");
        wait_idle(100, "post_reset_idle");
        check("post_reset_queue_empty", exp_q.size(), 0);

        // Strobe on the edge that samples the final tx_done
        push_packet(b1 ^ b2);
        base = mon_dv;
        strobe(b1 ^ b2);
        wait_dv(base + 26, 1000, "coincident_packet");
        repeat (18) @(posedge clk);
        #1;
        frame_strobe = 1'b1;
        @(posedge clk);
        #1;
        frame_strobe = 1'b0;
        check("coincident_busy_low", int'(busy), 0);
        check("coincident_dropped", int'(drop_count), 1);
        repeat (60) @(negedge clk);
        check("coincident_no_new_packet", mon_dv - base, 26);

        // enable falling mid-packet lets it finish; later strobes are ignored
        push_packet(b2 << 11);
        base = mon_dv;
        strobe(b2 << 11);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        wait_dv(base + 26, 1000, "enable_low_packet_finishes");
        wait_idle(100, "enable_low_idle");
        strobe(b1);
        repeat (30) @(negedge clk);
        check("disabled_strobe_no_busy", int'(busy), 0);
        check("disabled_strobe_not_counted", int'(drop_count), 1);
        check("disabled_strobe_no_bytes", mon_dv - base, 26);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
